// File: rtl/xsr_pkg.sv
// Shared definitions for the xs serial pair (xst transmitter / xsr receiver).
// Holds the receiver state encoding and the bus-side widths.
package xsr_pkg;

    localparam int unsigned FRAME_W = 64;
    localparam int unsigned BAUD_W  = 16;
    localparam int unsigned BITS_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_DATA   = 2'd2,
        ST_WAITHI = 2'd3
    } xs_state_t;

endpackage

// File: rtl/xs_brg.sv
// Loadable baud down-counter with zero flag; shared by xst and xsr.
// Load wins over decrement, and decrement stops at zero.
module xs_brg
    import xsr_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              load_i,
    input  logic [BAUD_W-1:0] val_i,
    input  logic              dec_i,
    output logic [BAUD_W-1:0] cnt_o,
    output logic              zero_o
);

    logic [BAUD_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - BAUD_W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/xsr.sv
// Asynchronous serial receiver: mid-bit sampling of a bits_i-long frame, LSB
// (start bit) first, into a 64-bit holding register with full/ferr/overrun flags.
module xsr
    import xsr_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               rxd_i,
    input  logic [BITS_W-1:0]  bits_i,
    input  logic [BAUD_W-1:0]  rxbaud_i,
    input  logic               rxreg_re_i,
    output logic [FRAME_W-1:0] dat_o,
    output logic               full_o,
    output logic               ferr_o,
    output logic               overrun_o,
    output logic               idle_o,
    output logic [BAUD_W-1:0]  brg_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd;

    xs_state_t          state_q, state_d;
    logic [BITS_W-1:0]  len_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [BITS_W-1:0]  cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic               done_q;
    logic               stop_q;

    logic               brg_load;
    logic [BAUD_W-1:0]  brg_val;
    logic               brg_dec;
    logic               brg_zero;
    logic               start_det;
    logic               sample_en;
    logic               frame_end;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
        end
    end

    assign rxd = sync_q[SYNC_STAGES-1];

    xs_brg u_brg (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .load_i   (brg_load),
        .val_i    (brg_val),
        .dec_i    (brg_dec),
        .cnt_o    (brg_o),
        .zero_o   (brg_zero)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        brg_load  = 1'b0;
        brg_val   = baud_q;
        brg_dec   = 1'b0;
        start_det = 1'b0;
        sample_en = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxd) begin
                    start_det = 1'b1;
                    brg_load  = 1'b1;
                    brg_val   = {1'b0, rxbaud_i[BAUD_W-1:1]};
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (!brg_zero) begin
                    brg_dec = 1'b1;
                end else if (rxd) begin
                    state_d = ST_IDLE;
                end else begin
                    sample_en = 1'b1;
                    brg_load  = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!brg_zero) begin
                    brg_dec = 1'b1;
                end else begin
                    sample_en = 1'b1;
                    brg_load  = 1'b1;
                    if (cnt_q == len_q - BITS_W'(1)) begin
                        frame_end = 1'b1;
                        state_d   = rxd ? ST_IDLE : ST_WAITHI;
                    end
                end
            end
            ST_WAITHI: begin
                if (rxd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift register is cleared on start detect so bits beyond a short frame read as 0.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            len_q   <= BITS_W'(2);
            baud_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (frame_end) begin
                stop_q <= rxd;
            end
            if (start_det) begin
                len_q   <= (bits_i < BITS_W'(2)) ? BITS_W'(2) : bits_i;
                baud_q  <= rxbaud_i;
                cnt_q   <= '0;
                shift_q <= '0;
            end else if (sample_en) begin
                shift_q[cnt_q] <= rxd;
                cnt_q          <= cnt_q + BITS_W'(1);
            end
        end
    end

    // A read in the completion cycle frees the slot for the new frame.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dat_o     <= '0;
            full_o    <= 1'b0;
            ferr_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else if (done_q) begin
            if (!full_o || rxreg_re_i) begin
                dat_o  <= shift_q;
                full_o <= 1'b1;
                ferr_o <= ~stop_q;
                if (rxreg_re_i) begin
                    overrun_o <= 1'b0;
                end
            end else begin
                overrun_o <= 1'b1;
            end
        end else if (rxreg_re_i) begin
            full_o    <= 1'b0;
            overrun_o <= 1'b0;
        end
    end

    assign idle_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_xsr.sv
// Scoreboard bench for xsr: stimulus pushes expected holding-register state,
// a negedge monitor pops and compares whenever the receiver presents a result.
module tb_xsr;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        rxd_i;
    logic [5:0]  bits_i;
    logic [15:0] rxbaud_i;
    logic        rxreg_re_i;
    logic [63:0] dat_o;
    logic        full_o;
    logic        ferr_o;
    logic        overrun_o;
    logic        idle_o;
    logic [15:0] brg_o;

    xsr #(.SYNC_STAGES(2)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .rxd_i      (rxd_i),
        .bits_i     (bits_i),
        .rxbaud_i   (rxbaud_i),
        .rxreg_re_i (rxreg_re_i),
        .dat_o      (dat_o),
        .full_o     (full_o),
        .ferr_o     (ferr_o),
        .overrun_o  (overrun_o),
        .idle_o     (idle_o),
        .brg_o      (brg_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [63:0] dat;
        logic        ferr;
        logic        ovr;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    logic [63:0] prev_dat;
    logic        prev_full;
    logic        prev_ovr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input string name, input logic [63:0] dat,
                             input logic ferr, input logic ovr);
        exp_t e;
        e.name = name;
        e.dat  = dat;
        e.ferr = ferr;
        e.ovr  = ovr;
        sbq.push_back(e);
    endtask

    always @(negedge clk_i) begin
        if (!reset_ni) begin
            prev_dat  = dat_o;
            prev_full = full_o;
            prev_ovr  = overrun_o;
        end else begin
            if ((full_o && !prev_full) || (dat_o !== prev_dat) || (overrun_o && !prev_ovr)) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event actual dat=%h ferr=%b ovr=%b full=%b expected none",
                             dat_o, ferr_o, overrun_o, full_o);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (dat_o !== e.dat || ferr_o !== e.ferr || overrun_o !== e.ovr || full_o !== 1'b1) begin
                        failures++;
                        $display("FAIL %s actual dat=%h ferr=%b ovr=%b full=%b expected dat=%h ferr=%b ovr=%b full=1",
                                 e.name, dat_o, ferr_o, overrun_o, full_o, e.dat, e.ferr, e.ovr);
                    end
                end
            end
            prev_dat  = dat_o;
            prev_full = full_o;
            prev_ovr  = overrun_o;
        end
    end

    // Caller is 1 time unit after a posedge; returns likewise after the last bit period.
    task automatic drive_bits(input logic [63:0] frame, input int first, input int last, input int baud);
        for (int k = first; k <= last; k++) begin
            rxd_i = frame[k];
            repeat (baud + 1) @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_frame(input logic [63:0] frame, input int len, input int baud,
                              input bit read_at_done);
        drive_bits(frame, 0, len - 1, baud);
        rxd_i = 1'b1;
        if (read_at_done) begin
            @(posedge clk_i); #1;
            rxreg_re_i = 1'b1;
            @(posedge clk_i); #1;
            rxreg_re_i = 1'b0;
        end
    endtask

    task automatic read_pulse();
        @(posedge clk_i); #1;
        rxreg_re_i = 1'b1;
        @(posedge clk_i); #1;
        rxreg_re_i = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_ni   = 1'b0;
        rxd_i      = 1'b1;
        bits_i     = 6'd11;
        rxbaud_i   = 16'd4;
        rxreg_re_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_dat", dat_o, 64'h0);
        chk("reset_flags", {60'h0, full_o, ferr_o, overrun_o, idle_o}, 64'h1);
        chk("reset_brg", {48'h0, brg_o}, 64'h0);
        reset_ni = 1'b1;
        gap(5);

        // nominal frame
        expect_ev("nominal", 64'h622, 1'b0, 1'b0);
        send_frame(64'h622, 11, 4, 1'b0);
        gap(8);
        chk("nominal_idle", {63'h0, idle_o}, 64'h1);
        read_pulse();
        chk("nominal_read_full", {63'h0, full_o}, 64'h0);
        gap(3);

        // glitch rejection
        rxd_i = 1'b0;
        gap(2);
        rxd_i = 1'b1;
        gap(12);
        chk("glitch_idle", {63'h0, idle_o}, 64'h1);
        chk("glitch_full", {63'h0, full_o}, 64'h0);
        chk("glitch_dat", dat_o, 64'h622);

        // framing error on a held-low line
        expect_ev("framing_err", 64'h222, 1'b1, 1'b0);
        drive_bits(64'h222, 0, 10, 4);
        gap(20);
        chk("break_not_idle", {63'h0, idle_o}, 64'h0);
        rxd_i = 1'b1;
        gap(6);
        chk("break_release_idle", {63'h0, idle_o}, 64'h1);
        read_pulse();
        gap(3);

        // overrun, then read clears flags
        expect_ev("ovr_first", 64'h622, 1'b0, 1'b0);
        send_frame(64'h622, 11, 4, 1'b0);
        gap(8);
        expect_ev("ovr_dropped", 64'h622, 1'b0, 1'b1);
        send_frame(64'h3FE, 11, 4, 1'b0);
        gap(8);
        chk("ovr_dat_kept", dat_o, 64'h622);
        read_pulse();
        chk("ovr_read_clears", {62'h0, full_o, overrun_o}, 64'h0);
        gap(3);

        // read coincident with completion
        expect_ev("coinc_first", 64'h622, 1'b0, 1'b0);
        send_frame(64'h622, 11, 4, 1'b0);
        gap(8);
        expect_ev("coinc_second", 64'h7FE, 1'b0, 1'b0);
        send_frame(64'h7FE, 11, 4, 1'b1);
        gap(6);
        chk("coinc_full_ovr", {62'h0, full_o, overrun_o}, 64'h2);
        read_pulse();
        gap(3);

        // bits_i below 2 is a two-bit frame; upper bits read as zero
        bits_i = 6'd1;
        expect_ev("short_frame", 64'h2, 1'b0, 1'b0);
        send_frame(64'h2, 2, 4, 1'b0);
        gap(8);
        read_pulse();
        bits_i = 6'd11;
        gap(3);

        // reset mid-frame
        drive_bits(64'h622, 0, 3, 4);
        chk("mid_frame_busy", {63'h0, idle_o}, 64'h0);
        reset_ni = 1'b0;
        #1;
        chk("midrst_dat", dat_o, 64'h0);
        chk("midrst_flags", {60'h0, full_o, ferr_o, overrun_o, idle_o}, 64'h1);
        chk("midrst_brg", {48'h0, brg_o}, 64'h0);
        rxd_i = 1'b1;
        gap(3);
        reset_ni = 1'b1;
        gap(5);
        expect_ev("after_reset", 64'h622, 1'b0, 1'b0);
        send_frame(64'h622, 11, 4, 1'b0);

        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk_i);
        gap(2);
        chk("pending_events", 64'(sbq.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
